// File: rtl/usb_fifo_drain_tx_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the USB FIFO to FX2 EP6 drain path.
package usb_fifo_drain_tx_pkg;

   // Words per full USB bulk packet (512 bytes of 16-bit words).
   localparam int USB_PACKET_WORDS = 256;

   // FX2 endpoint select for EP6.
   localparam logic [1:0] FIFOADR_EP6 = 2'b10;

   // Drain FSM encoding. These values are visible on the debug state port.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_READ   = 3'd2,
      ST_LATCH  = 3'd3,
      ST_WRITE  = 3'd4,
      ST_PKTEND = 3'd5,
      ST_DONE   = 3'd6
   } drain_state_e;

   // Packet word counter step: wraps to zero after the last word of a packet.
   // The FX2 commits full packets on its own, so the wrap needs no strobe.
   function automatic logic [7:0] next_word_cnt(input logic [7:0] cnt,
                                                input logic [7:0] last);
      return (cnt == last) ? 8'd0 : cnt + 8'd1;
   endfunction

endpackage

// File: rtl/start_stop_edge_detect.sv
`timescale 1ns/1ps
// Falling-edge detector for the run enable. The previous level is held in a
// register so the edge is seen exactly one cycle after the input drops.
module start_stop_edge_detect (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_stop_i,
   output logic fall_o
);

   logic start_stop_q;
   logic start_stop_d;

   // Next value of the edge register is simply the current level.
   always_comb begin
      start_stop_d = start_stop_i;
   end

   // Edge register, cleared by the asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         start_stop_q <= 1'b0;
      end else begin
         start_stop_q <= start_stop_d;
      end
   end

   assign fall_o = start_stop_q & ~start_stop_i;

endmodule

// File: rtl/usb_fifo_drain_tx.sv
`timescale 1ns/1ps
// usb_fifo_drain_tx: moves words from the USB data FIFO to the FX2 EP6 slave
// FIFO at one word per four clocks and commits a trailing short packet when a
// flush (run enable falling, or S-curve test done) has been requested.
//
// Strobe protocol: usb_data_fifo_rd_en is high for exactly one cycle (READ)
// and the FIFO presents the word one cycle later (LATCH), where it is captured
// into FD_out. nSLWR is low for exactly one cycle (WRITE) with FD_out already
// stable. nPKTEND is low for exactly one cycle (PKTEND). The FX2 full flag is
// only looked at in CHECK, so a word that has started always finishes.
module usb_fifo_drain_tx
   import usb_fifo_drain_tx_pkg::*;
#(
   parameter int PACKET_WORDS = USB_PACKET_WORDS
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        Start_Stop,
   input  logic        SCTest_Done,
   input  logic [15:0] usb_data_fifo_dout,
   input  logic        usb_data_fifo_empty,
   output logic        usb_data_fifo_rd_en,
   input  logic        nFLAGB,
   output logic [15:0] FD_out,
   output logic        nSLWR,
   output logic        nPKTEND,
   output logic [1:0]  FIFOADR,
   output logic        Data_Transmit_Done,
   output logic [2:0]  fsm_state_o,
   output logic [7:0]  word_cnt_o
);

   localparam logic [7:0] LAST_WORD = 8'(PACKET_WORDS - 1);

   drain_state_e state_q;
   logic         rd_en_q;
   logic [15:0]  fd_q;
   logic         nslwr_q;
   logic         npktend_q;
   logic         done_q;
   logic [7:0]   word_cnt_q;
   logic         flush_pending_q;
   logic         flush_pending_d;
   logic         start_stop_fall;
   logic         flush_req;

   start_stop_edge_detect u_edge (
      .clk_i        (Clk),
      .rst_i        (reset),
      .start_stop_i (Start_Stop),
      .fall_o       (start_stop_fall)
   );

   // A flush request only counts once a run is under way.
   assign flush_req = (state_q != ST_IDLE) && (start_stop_fall || SCTest_Done);

   // Flush request is sticky until the FSM returns to IDLE.
   always_comb begin
      flush_pending_d = flush_pending_q;
      if (state_q == ST_IDLE) begin
         flush_pending_d = 1'b0;
      end else if (flush_req) begin
         flush_pending_d = 1'b1;
      end
   end

   // Flush pending register.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         flush_pending_q <= 1'b0;
      end else begin
         flush_pending_q <= flush_pending_d;
      end
   end

   // Drain FSM with registered strobes, data bus and word counter.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rd_en_q    <= 1'b0;
         fd_q       <= 16'h0000;
         nslwr_q    <= 1'b1;
         npktend_q  <= 1'b1;
         done_q     <= 1'b0;
         word_cnt_q <= 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (Start_Stop) begin
                  state_q <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (!usb_data_fifo_empty && nFLAGB) begin
                  state_q <= ST_READ;
                  rd_en_q <= 1'b1;
               end else if (flush_pending_q && usb_data_fifo_empty) begin
                  if (word_cnt_q != 8'd0) begin
                     state_q   <= ST_PKTEND;
                     npktend_q <= 1'b0;
                  end else begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               rd_en_q <= 1'b0;
               state_q <= ST_LATCH;
            end
            ST_LATCH: begin
               fd_q    <= usb_data_fifo_dout;
               nslwr_q <= 1'b0;
               state_q <= ST_WRITE;
            end
            ST_WRITE: begin
               nslwr_q    <= 1'b1;
               word_cnt_q <= next_word_cnt(word_cnt_q, LAST_WORD);
               state_q    <= ST_CHECK;
            end
            ST_PKTEND: begin
               npktend_q  <= 1'b1;
               word_cnt_q <= 8'd0;
               done_q     <= 1'b1;
               state_q    <= ST_DONE;
            end
            ST_DONE: begin
               // A new run may only start after IDLE has been seen again.
               if (!Start_Stop && !SCTest_Done) begin
                  done_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               rd_en_q   <= 1'b0;
               nslwr_q   <= 1'b1;
               npktend_q <= 1'b1;
               done_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign usb_data_fifo_rd_en = rd_en_q;
   assign FD_out              = fd_q;
   assign nSLWR               = nslwr_q;
   assign nPKTEND             = npktend_q;
   assign FIFOADR             = FIFOADR_EP6;
   assign Data_Transmit_Done  = done_q;
   assign fsm_state_o         = state_q;
   assign word_cnt_o          = word_cnt_q;

endmodule

// File: tb/tb_usb_fifo_drain_tx.sv
`timescale 1ns/1ps
// Bench for usb_fifo_drain_tx: FIFO model plus event recorder, one task per
// scenario, reference expectations derived from the words pushed.
module tb_usb_fifo_drain_tx;

  localparam int PW = 256;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  // clock / reset
  logic Clk = 1'b0;
  logic reset = 1'b1;
  always #5 Clk = ~Clk;

  logic        Start_Stop = 1'b0;
  logic        SCTest_Done = 1'b0;
  logic        nFLAGB = 1'b1;
  logic [15:0] usb_data_fifo_dout = 16'h0000;
  logic        usb_data_fifo_empty = 1'b1;
  logic        usb_data_fifo_rd_en;
  logic [15:0] FD_out;
  logic        nSLWR;
  logic        nPKTEND;
  logic [1:0]  FIFOADR;
  logic        Data_Transmit_Done;
  logic [2:0]  fsm_state_o;
  logic [7:0]  word_cnt_o;

  usb_fifo_drain_tx #(.PACKET_WORDS(PW)) dut (
    .Clk                 (Clk),
    .reset               (reset),
    .Start_Stop          (Start_Stop),
    .SCTest_Done         (SCTest_Done),
    .usb_data_fifo_dout  (usb_data_fifo_dout),
    .usb_data_fifo_empty (usb_data_fifo_empty),
    .usb_data_fifo_rd_en (usb_data_fifo_rd_en),
    .nFLAGB              (nFLAGB),
    .FD_out              (FD_out),
    .nSLWR               (nSLWR),
    .nPKTEND             (nPKTEND),
    .FIFOADR             (FIFOADR),
    .Data_Transmit_Done  (Data_Transmit_Done),
    .fsm_state_o         (fsm_state_o),
    .word_cnt_o          (word_cnt_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] wr_words[$];
  int          wr_times[$];
  int          pkt_cnt = 0;
  int          pkt_cyc = 0;
  bit          done_seen = 0;

  always @(posedge Clk) cyc++;

  // FIFO model (read data appears after the rd_en cycle) and event recorder.
  always @(negedge Clk) begin
    if (usb_data_fifo_rd_en && fifo_q.size() > 0) usb_data_fifo_dout = fifo_q.pop_front();
    usb_data_fifo_empty = (fifo_q.size() == 0);
    if (!nSLWR) begin
      wr_words.push_back(FD_out);
      wr_times.push_back(cyc);
    end
    if (!nPKTEND) begin
      pkt_cnt++;
      pkt_cyc = cyc;
    end
    if (Data_Transmit_Done) done_seen = 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic clear_logs();
    wr_words.delete();
    wr_times.delete();
    exp_q.delete();
    pkt_cnt = 0;
    done_seen = 0;
  endtask

  task automatic preload(input int n, input bit rnd, input logic [15:0] base);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? 16'($urandom) : base + 16'(i);
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (Data_Transmit_Done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (fsm_state_o == s) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (wr_words.size() >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic finish_run();
    bit ok;
    Start_Stop = 0;
    SCTest_Done = 0;
    wait_state(S_IDLE, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL return_idle: state=%0d required=%0d", fsm_state_o, S_IDLE);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge Clk);
    checks++; if (usb_data_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b required 0", usb_data_fifo_rd_en); end
    checks++; if (FD_out !== 16'h0000) begin errors++; $display("FAIL reset_fd_out: got %h required 0000", FD_out); end
    checks++; if (nSLWR !== 1'b1) begin errors++; $display("FAIL reset_nslwr: got %b required 1", nSLWR); end
    checks++; if (nPKTEND !== 1'b1) begin errors++; $display("FAIL reset_npktend: got %b required 1", nPKTEND); end
    checks++; if (FIFOADR !== 2'b10) begin errors++; $display("FAIL reset_fifoadr: got %b required 10", FIFOADR); end
    checks++; if (Data_Transmit_Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", Data_Transmit_Done); end
    checks++; if (fsm_state_o !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", fsm_state_o, S_IDLE); end
    checks++; if (word_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_word_cnt: got %0d required 0", word_cnt_o); end
    reset = 0;
    repeat (2) @(negedge Clk);
    checks++; if (fsm_state_o !== S_IDLE) begin errors++; $display("FAIL idle_hold: got %0d required %0d", fsm_state_o, S_IDLE); end
  endtask

  task automatic test_short_packet();
    bit ok;
    int bad;
    clear_logs();
    preload(3, 0, 16'h0001);
    Start_Stop = 1;
    @(negedge Clk);
    Start_Stop = 0;
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL short_done: got 0 required 1"); end
    finish_run();
    checks++; if (wr_words.size() != 3) begin errors++; $display("FAIL short_count: got %0d required 3", wr_words.size()); end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < wr_words.size(); i++) if (wr_words[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL short_data: got %0d bad words required 0", bad); end
    bad = 0;
    for (int i = 1; i < wr_times.size(); i++) if (wr_times[i] - wr_times[i-1] != 4) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL short_spacing: got %0d gaps not 4 required 0", bad); end
    checks++; if (pkt_cnt != 1) begin errors++; $display("FAIL short_pktend: got %0d required 1", pkt_cnt); end
    checks++; if (wr_times.size() > 0 && pkt_cyc <= wr_times[wr_times.size()-1]) begin errors++; $display("FAIL short_pkt_order: pktend cycle %0d not after last write %0d", pkt_cyc, wr_times[wr_times.size()-1]); end
    checks++; if (Data_Transmit_Done !== 1'b0) begin errors++; $display("FAIL short_done_clear: got %b required 0", Data_Transmit_Done); end
  endtask

  task automatic test_full_packet();
    bit ok;
    int bad;
    clear_logs();
    preload(PW, 1, 16'h0);
    Start_Stop = 1;
    wait_writes(PW, 1500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_drain: got %0d writes required %0d", wr_words.size(), PW); end
    repeat (3) @(negedge Clk);
    SCTest_Done = 1;
    wait_done(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_done: got 0 required 1"); end
    repeat (3) @(negedge Clk);
    checks++; if (Data_Transmit_Done !== 1'b1) begin errors++; $display("FAIL full_done_hold: got %b required 1", Data_Transmit_Done); end
    checks++; if (word_cnt_o !== 8'(PW % PW)) begin errors++; $display("FAIL full_word_cnt: got %0d required %0d", word_cnt_o, PW % PW); end
    checks++; if (pkt_cnt != 0) begin errors++; $display("FAIL full_pktend: got %0d required 0", pkt_cnt); end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < wr_words.size(); i++) if (wr_words[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0 || wr_words.size() != PW) begin errors++; $display("FAIL full_data: got %0d bad of %0d required 0 of %0d", bad, wr_words.size(), PW); end
    finish_run();
  endtask

  task automatic test_flagb_stall();
    bit ok;
    bit resumed;
    int viol;
    int bad;
    clear_logs();
    preload(16, 1, 16'h0);
    Start_Stop = 1;
    wait_writes(4, 100, ok);
    nFLAGB = 0;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (i >= 2 && (usb_data_fifo_rd_en || !nSLWR)) viol++;
    end
    nFLAGB = 1;
    resumed = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      if (usb_data_fifo_rd_en) resumed = 1;
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL stall_quiet: got %0d strobe cycles required 0", viol); end
    checks++; if (!resumed) begin errors++; $display("FAIL stall_resume: got no rd_en required rd_en within 2 clocks"); end
    Start_Stop = 0;
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_done: got 0 required 1"); end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < wr_words.size(); i++) if (wr_words[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0 || wr_words.size() != 16) begin errors++; $display("FAIL stall_data: got %0d bad of %0d required 0 of 16", bad, wr_words.size()); end
    checks++; if (pkt_cnt != 1) begin errors++; $display("FAIL stall_pktend: got %0d required 1", pkt_cnt); end
    finish_run();
  endtask

  task automatic test_flush_in_latch();
    bit ok;
    bit ok2;
    int bad;
    clear_logs();
    preload(2, 1, 16'h0);
    Start_Stop = 1;
    wait_writes(1, 50, ok);
    wait_state(S_LATCH, 20, ok2);
    Start_Stop = 0;
    checks++; if (!(ok && ok2)) begin errors++; $display("FAIL latch_reach: got %b%b required 11", ok, ok2); end
    wait_done(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL latch_done: got 0 required 1"); end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < wr_words.size(); i++) if (wr_words[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0 || wr_words.size() != 2) begin errors++; $display("FAIL latch_data: got %0d bad of %0d required 0 of 2", bad, wr_words.size()); end
    checks++; if (pkt_cnt != 1) begin errors++; $display("FAIL latch_pktend: got %0d required 1", pkt_cnt); end
    checks++; if (wr_times.size() > 0 && pkt_cyc <= wr_times[wr_times.size()-1]) begin errors++; $display("FAIL latch_pkt_order: pktend cycle %0d not after last write %0d", pkt_cyc, wr_times[wr_times.size()-1]); end
    finish_run();
  endtask

  task automatic test_random_bursts();
    bit ok;
    int n;
    int bad;
    int gap;
    for (int it = 0; it < 3; it++) begin
      clear_logs();
      n = $urandom_range(1, 40);
      preload(n, 1, 16'h0);
      Start_Stop = 1;
      repeat ($urandom_range(1, 4 * n)) @(negedge Clk);
      Start_Stop = 0;
      wait_done(4 * n + 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_done[%0d]: got 0 required 1", it); end
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < wr_words.size(); i++) if (wr_words[i] !== exp_q[i]) bad++;
      checks++; if (bad != 0 || wr_words.size() != n) begin errors++; $display("FAIL rand_data[%0d]: got %0d bad of %0d required 0 of %0d", it, bad, wr_words.size(), n); end
      checks++; if (pkt_cnt != ((n % PW) != 0 ? 1 : 0)) begin errors++; $display("FAIL rand_pktend[%0d]: got %0d required %0d", it, pkt_cnt, ((n % PW) != 0 ? 1 : 0)); end
      gap = 0;
      for (int i = 1; i < wr_times.size(); i++) if (wr_times[i] - wr_times[i-1] != 4) gap++;
      checks++; if (gap != 0) begin errors++; $display("FAIL rand_spacing[%0d]: got %0d gaps not 4 required 0", it, gap); end
      finish_run();
    end
  endtask

  task automatic test_empty_pulse();
    bit ok;
    clear_logs();
    Start_Stop = 1;
    @(negedge Clk);
    Start_Stop = 0;
    wait_done(30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL empty_done: got 0 required 1"); end
    checks++; if (wr_words.size() != 0) begin errors++; $display("FAIL empty_writes: got %0d required 0", wr_words.size()); end
    checks++; if (pkt_cnt != 0) begin errors++; $display("FAIL empty_pktend: got %0d required 0", pkt_cnt); end
    finish_run();
  endtask

  task automatic test_reset_in_write();
    bit ok;
    clear_logs();
    preload(5, 1, 16'h0);
    Start_Stop = 1;
    wait_state(S_WRITE, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_reach_write: got state %0d required %0d", fsm_state_o, S_WRITE); end
    reset = 1;
    Start_Stop = 0;
    #1;
    checks++; if (nSLWR !== 1'b1) begin errors++; $display("FAIL rst_nslwr_immediate: got %b required 1", nSLWR); end
    @(negedge Clk);
    checks++; if (nSLWR !== 1'b1) begin errors++; $display("FAIL rst_nslwr: got %b required 1", nSLWR); end
    checks++; if (usb_data_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b required 0", usb_data_fifo_rd_en); end
    checks++; if (FD_out !== 16'h0000) begin errors++; $display("FAIL rst_fd_out: got %h required 0000", FD_out); end
    checks++; if (fsm_state_o !== S_IDLE) begin errors++; $display("FAIL rst_state: got %0d required %0d", fsm_state_o, S_IDLE); end
    checks++; if (nPKTEND !== 1'b1) begin errors++; $display("FAIL rst_npktend: got %b required 1", nPKTEND); end
    fifo_q.delete();
    repeat (2) @(negedge Clk);
    reset = 0;
    repeat (2) @(negedge Clk);
    checks++; if (fsm_state_o !== S_IDLE) begin errors++; $display("FAIL rst_release_idle: got %0d required %0d", fsm_state_o, S_IDLE); end
  endtask

  initial begin
    test_reset();
    test_short_packet();
    test_full_packet();
    test_flagb_stall();
    test_flush_in_latch();
    test_random_bursts();
    test_empty_pulse();
    test_reset_in_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_fifo_drain_tx.md
USB_FIFO_DRAIN_TX -- requirements
Module: usb_fifo_drain_tx

Interface
REQ-001 SHALL have port Clk, input, 1, single system clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port Start_Stop, input, 1, muxed acquisition/S-curve run enable (1 = run).
REQ-004 SHALL have port SCTest_Done, input, 1, level; S-curve test finished, flush request.
REQ-005 SHALL have port usb_data_fifo_dout, input, 16, USB data FIFO read data, valid 1 cycle after rd_en.
REQ-006 SHALL have port usb_data_fifo_empty, input, 1, USB data FIFO empty flag.
REQ-007 SHALL have port usb_data_fifo_rd_en, output, 1, USB data FIFO read strobe.
REQ-008 SHALL have port nFLAGB, input, 1, FX2 EP6 full flag, active low (0 = full).
REQ-009 SHALL have port FD_out, output, 16, FX2 slave FIFO data bus.
REQ-010 SHALL have port nSLWR, output, 1, FX2 write strobe, active low.
REQ-011 SHALL have port nPKTEND, output, 1, FX2 short-packet commit, active low.
REQ-012 SHALL have port FIFOADR, output, 2, FX2 endpoint select, constant 2'b10 (EP6).
REQ-013 SHALL have port Data_Transmit_Done, output, 1, all data committed to host.
REQ-014 SHALL have parameter PACKET_WORDS, default 256, words per full USB packet (512 B).

Function
REQ-015 SHALL implement FSM states IDLE, CHECK, READ, LATCH, WRITE, PKTEND, DONE.
REQ-016 IDLE SHALL go to CHECK when Start_Stop=1; else stay.
REQ-017 CHECK SHALL go to READ when empty=0 and nFLAGB=1; else, when flush_pending=1 and empty=1, to PKTEND if word_cnt!=0 or DONE if word_cnt=0; else stay.
REQ-018 READ SHALL assert usb_data_fifo_rd_en for exactly that one cycle, then go to LATCH.
REQ-019 LATCH SHALL register usb_data_fifo_dout into FD_out, then go to WRITE.
REQ-020 WRITE SHALL drive nSLWR=0 for exactly one cycle with FD_out stable, increment word_cnt, then go to CHECK.
REQ-021 word_cnt SHALL be 8 bits, wrap PACKET_WORDS-1 -> 0 with no nPKTEND (FX2 auto-commits full packets).
REQ-022 PKTEND SHALL drive nPKTEND=0 for exactly one cycle, clear word_cnt, then go to DONE.
REQ-023 DONE SHALL hold Data_Transmit_Done=1 and go to IDLE when Start_Stop=0 and SCTest_Done=0.
REQ-024 flush_pending SHALL set on a registered Start_Stop 1->0 edge or SCTest_Done=1 while not IDLE, and clear in IDLE.
REQ-025 Flush arriving during READ/LATCH/WRITE SHALL let the in-flight word complete; flush evaluated in next CHECK.
REQ-026 nFLAGB SHALL be sampled only in CHECK; a word already in READ/LATCH/WRITE SHALL complete.
REQ-027 Start_Stop rising while in DONE SHALL be ignored until IDLE is re-entered.
REQ-028 Throughput SHALL be one word per 4 clocks when FIFO non-empty and FX2 not full.

Reset
REQ-029 On reset SHALL force: state IDLE, rd_en=0, FD_out=16'h0000, nSLWR=1, nPKTEND=1, FIFOADR=2'b10, Data_Transmit_Done=0, word_cnt=0, flush_pending=0, edge register=0.
REQ-030 Reset mid-transfer SHALL abort immediately; no strobe SHALL be active in the cycle after reset assertion.

Structure
REQ-031 FSM state encoding, PACKET_WORDS and EP6 FIFOADR constant SHALL live in the shared USB package.
REQ-032 Start_Stop falling-edge detection SHALL be a sub-module named start_stop_edge_detect.

Verification
REQ-033 FIFO preloaded 3 words 16'h0001..0003, Start_Stop=1 then 0 -> 3 nSLWR pulses 4 clocks apart, FD_out matches, one nPKTEND, Data_Transmit_Done=1.
REQ-034 FIFO 256 words, SCTest_Done=1 after drain -> 256 nSLWR pulses, word_cnt wraps to 0, no nPKTEND, Data_Transmit_Done=1.
REQ-035 nFLAGB=0 for 20 clocks mid-stream -> no rd_en/nSLWR while low, resumes within 2 clocks of nFLAGB=1, no word lost or duplicated.
REQ-036 Start_Stop falls in LATCH with FIFO then empty -> current word written, then nPKTEND, then DONE.
REQ-037 reset asserted during WRITE -> next cycle nSLWR=1, rd_en=0, FD_out=0, state IDLE.
REQ-038 Start_Stop pulses 1->0 with FIFO empty -> no nSLWR, no nPKTEND, Data_Transmit_Done=1.
